// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode fields, hazard controls and forwarding sources in,
// ALU operands and EX-stage controls out.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [REGW-1:0] id_rd;
  logic [XLEN-1:0] id_imm;
  logic            id_alusrc;
  logic [3:0]      id_aluop;
  logic            id_regwrite;
  logic            id_memread;
  logic            id_memwrite;
  logic            ex_hold;
  logic            flush;
  logic [REGW-1:0] mem_rd;
  logic            mem_regwrite;
  logic [XLEN-1:0] mem_result;
  logic [REGW-1:0] wb_rd;
  logic            wb_regwrite;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] alu_x;
  logic [XLEN-1:0] alu_y;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [REGW-1:0] ex_rd;
  logic            ex_valid;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            stall_id;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
           id_imm, id_alusrc, id_aluop, id_regwrite, id_memread, id_memwrite,
           ex_hold, flush, mem_rd, mem_regwrite, mem_result,
           wb_rd, wb_regwrite, wb_result,
    input  alu_x, alu_y, alu_op, ex_store_data, ex_pc, ex_rd, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, stall_id
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
           id_imm, id_alusrc, id_aluop, id_regwrite, id_memread, id_memwrite,
           ex_hold, flush, mem_rd, mem_regwrite, mem_result,
           wb_rd, wb_regwrite, wb_result,
    output alu_x, alu_y, alu_op, ex_store_data, ex_pc, ex_rd, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, stall_id
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use stall detection, flush and downstream hold.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [3:0]      aluop;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } ex_reg_t;

  ex_reg_t         ex_q;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic            stall;

  // Operand forwarding: youngest producer (EX/MEM) wins; x0 is hard zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fwd_rs1 = ex_q.rs1_data;
    if (ex_q.rs1 == '0)
      fwd_rs1 = '0;
    else if (bus.mem_regwrite && bus.mem_rd == ex_q.rs1)
      fwd_rs1 = bus.mem_result;
    else if (bus.wb_regwrite && bus.wb_rd == ex_q.rs1)
      fwd_rs1 = bus.wb_result;

    fwd_rs2 = ex_q.rs2_data;
    if (ex_q.rs2 == '0)
      fwd_rs2 = '0;
    else if (bus.mem_regwrite && bus.mem_rd == ex_q.rs2)
      fwd_rs2 = bus.mem_result;
    else if (bus.wb_regwrite && bus.wb_rd == ex_q.rs2)
      fwd_rs2 = bus.wb_result;
  end

  // Register-file write-through: a value retiring this cycle is not yet in the file.
  always_comb begin
    cap_rs1 = bus.id_rs1_data;
    cap_rs2 = bus.id_rs2_data;
    if (bus.wb_regwrite && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs1)
      cap_rs1 = bus.wb_result;
    if (bus.wb_regwrite && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs2)
      cap_rs2 = bus.wb_result;
  end

  // rs2 only matters when it feeds the ALU or is the store data.
  assign stall = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && bus.id_valid &&
                 ((bus.id_rs1 == ex_q.rd) ||
                  ((bus.id_rs2 == ex_q.rd) && (!bus.id_alusrc || bus.id_memwrite)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (bus.flush) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ex_q.valid <= 1'b0;
    end else if (bus.ex_hold) begin
      // Latch forwarded values so they survive their producers retiring.
      ex_q.rs1_data <= fwd_rs1;
      ex_q.rs2_data <= fwd_rs2;
    end else if (stall) begin
      ex_q.valid <= 1'b0;
    end else begin
      ex_q.valid    <= bus.id_valid;
      ex_q.pc       <= bus.id_pc;
      ex_q.rs1      <= bus.id_rs1;
      ex_q.rs2      <= bus.id_rs2;
      ex_q.rd       <= bus.id_rd;
      ex_q.rs1_data <= cap_rs1;
      ex_q.rs2_data <= cap_rs2;
      ex_q.imm      <= bus.id_imm;
      ex_q.alusrc   <= bus.id_alusrc;
      ex_q.aluop    <= bus.id_aluop;
      ex_q.regwrite <= bus.id_regwrite;
      ex_q.memread  <= bus.id_memread;
      ex_q.memwrite <= bus.id_memwrite;
    end
  end

  assign bus.alu_x         = fwd_rs1;
  assign bus.alu_y         = ex_q.alusrc ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.alu_op        = ex_q.aluop;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_regwrite   = ex_q.valid & ex_q.regwrite;
  assign bus.ex_memread    = ex_q.valid & ex_q.memread;
  assign bus.ex_memwrite   = ex_q.valid & ex_q.memwrite;
  assign bus.stall_id      = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random traffic
// predicted by a register-level reference model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();
  id_ex_stage #(.XLEN(32), .REGW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alusrc;
    logic [3:0]  id_aluop;
    logic        id_regwrite, id_memread, id_memwrite, ex_hold, flush;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
  } stim_t;

  // Instruction sitting in EX as the architecture sees it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        alusrc;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } slot_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_x, alu_y, store, pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw, stall;
  } exp_t;

  slot_t mdl;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Value of register r seen in EX: the most recent in-flight writer, else the held value.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] held, input stim_t s);
    if (r == 5'd0) return 32'd0;
    if (s.mem_regwrite && s.mem_rd == r) return s.mem_result;
    if (s.wb_regwrite && s.wb_rd == r) return s.wb_result;
    return held;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] data, input stim_t s);
    if (r != 5'd0 && s.wb_regwrite && s.wb_rd == r) return s.wb_result;
    return data;
  endfunction

  function automatic logic load_use(input stim_t s);
    if (!(mdl.valid && mdl.mr && mdl.rd != 5'd0 && s.id_valid)) return 1'b0;
    if (s.id_rs1 == mdl.rd) return 1'b1;
    return (s.id_rs2 == mdl.rd) && (!s.id_alusrc || s.id_memwrite);
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid = s.id_valid;       bus.id_pc = s.id_pc;
    bus.id_rs1 = s.id_rs1;           bus.id_rs2 = s.id_rs2;
    bus.id_rd = s.id_rd;             bus.id_imm = s.id_imm;
    bus.id_rs1_data = s.id_rs1_data; bus.id_rs2_data = s.id_rs2_data;
    bus.id_alusrc = s.id_alusrc;     bus.id_aluop = s.id_aluop;
    bus.id_regwrite = s.id_regwrite; bus.id_memread = s.id_memread;
    bus.id_memwrite = s.id_memwrite; bus.ex_hold = s.ex_hold;
    bus.flush = s.flush;
    bus.mem_rd = s.mem_rd;           bus.mem_regwrite = s.mem_regwrite;
    bus.mem_result = s.mem_result;
    bus.wb_rd = s.wb_rd;             bus.wb_regwrite = s.wb_regwrite;
    bus.wb_result = s.wb_result;
  endtask

  // Advance the model across the clock edge that consumes stimulus s.
  task automatic step_model(input stim_t s);
    slot_t n;
    n = mdl;
    if (s.flush) begin
      n.valid = 1'b0;
    end else if (s.ex_hold) begin
      n.v1 = newest(mdl.rs1, mdl.v1, s);
      n.v2 = newest(mdl.rs2, mdl.v2, s);
    end else if (load_use(s)) begin
      n.valid = 1'b0;
    end else begin
      n.valid = s.id_valid;  n.pc = s.id_pc;
      n.rs1 = s.id_rs1;      n.rs2 = s.id_rs2;   n.rd = s.id_rd;
      n.v1 = rf_read(s.id_rs1, s.id_rs1_data, s);
      n.v2 = rf_read(s.id_rs2, s.id_rs2_data, s);
      n.imm = s.id_imm;      n.alusrc = s.id_alusrc; n.op = s.id_aluop;
      n.rw = s.id_regwrite;  n.mr = s.id_memread;    n.mw = s.id_memwrite;
    end
    mdl = n;
  endtask

  task automatic drive_cycle(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    e.valid = mdl.valid;
    e.alu_x = newest(mdl.rs1, mdl.v1, s);
    e.store = newest(mdl.rs2, mdl.v2, s);
    e.alu_y = mdl.alusrc ? mdl.imm : e.store;
    e.pc    = mdl.pc;
    e.op    = mdl.op;
    e.rd    = mdl.rd;
    e.rw    = mdl.valid && mdl.rw;
    e.mr    = mdl.valid && mdl.mr;
    e.mw    = mdl.valid && mdl.mw;
    e.stall = load_use(s);
    q.push_back(e);
    step_model(s);
  endtask

  // Monitor: pops one prediction for every cycle the DUT presents.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
      check("ex_regwrite", 32'(bus.ex_regwrite), 32'(e.rw));
      check("ex_memread", 32'(bus.ex_memread), 32'(e.mr));
      check("ex_memwrite", 32'(bus.ex_memwrite), 32'(e.mw));
      check("stall_id", 32'(bus.stall_id), 32'(e.stall));
      if (e.valid) begin
        check("alu_x", bus.alu_x, e.alu_x);
        check("alu_y", bus.alu_y, e.alu_y);
        check("ex_store_data", bus.ex_store_data, e.store);
        check("alu_op", 32'(bus.alu_op), 32'(e.op));
        check("ex_pc", bus.ex_pc, e.pc);
        check("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, 32'(bus.ex_valid), 32'd0);
    check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
    check({tag, "_alu_x"}, bus.alu_x, 32'd0);
    check({tag, "_alu_y"}, bus.alu_y, 32'd0);
    check({tag, "_ex_rd"}, 32'(bus.ex_rd), 32'd0);
    check({tag, "_ctrl"}, {29'd0, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}, 32'd0);
    check({tag, "_stall_id"}, 32'(bus.stall_id), 32'd0);
  endtask

  // Assert reset between edges, check outputs immediately, release with s on the bus.
  task automatic async_reset(input string tag, input stim_t s);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    mdl = '0;
    q.delete();
    apply(s);
    step_model(s);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.id_valid = ($urandom_range(0, 9) < 8);
    s.id_pc = $urandom;
    s.id_rs1 = 5'($urandom_range(0, 7));
    s.id_rs2 = 5'($urandom_range(0, 7));
    s.id_rd = 5'($urandom_range(0, 7));
    s.id_rs1_data = $urandom;
    s.id_rs2_data = $urandom;
    s.id_imm = $urandom;
    s.id_alusrc = 1'($urandom_range(0, 1));
    s.id_aluop = 4'($urandom_range(0, 15));
    s.id_regwrite = 1'($urandom_range(0, 1));
    s.id_memread = ($urandom_range(0, 9) < 3);
    s.id_memwrite = !s.id_memread && ($urandom_range(0, 3) == 0);
    s.ex_hold = ($urandom_range(0, 9) < 2);
    s.flush = ($urandom_range(0, 19) == 0);
    s.mem_rd = 5'($urandom_range(0, 7));
    s.mem_regwrite = 1'($urandom_range(0, 1));
    s.mem_result = $urandom;
    s.wb_rd = 5'($urandom_range(0, 7));
    s.wb_regwrite = 1'($urandom_range(0, 1));
    s.wb_result = $urandom;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;
    mdl = '0;
    apply(idle);
    #3;
    check_reset_outputs("por");
    step_model(idle);
    #4;
    rst_n = 1'b1;

    // Plain capture with immediate operand.
    s = idle; s.id_valid = 1'b1; s.id_rs1 = 5'd2; s.id_rs1_data = 32'd5;
    s.id_imm = 32'd7; s.id_alusrc = 1'b1; s.id_aluop = 4'b0101;
    drive_cycle(s);
    drive_cycle(idle);
    @(negedge clk); #1;
    check("cap_alu_x", bus.alu_x, 32'd5);
    check("cap_alu_y", bus.alu_y, 32'd7);
    check("cap_alu_op", 32'(bus.alu_op), 32'b0101);
    check("cap_ex_valid", 32'(bus.ex_valid), 32'd1);

    // Forwarding priority, then x0 immunity.
    s = idle; s.id_valid = 1'b1; s.id_rs1 = 5'd3; s.id_rs1_data = 32'h11;
    drive_cycle(s);
    s = idle; s.ex_hold = 1'b1;
    s.mem_rd = 5'd3; s.mem_regwrite = 1'b1; s.mem_result = 32'hAA;
    s.wb_rd = 5'd3; s.wb_regwrite = 1'b1; s.wb_result = 32'hBB;
    drive_cycle(s);
    @(negedge clk); #1;
    check("fwd_mem_wins", bus.alu_x, 32'hAA);
    s.mem_regwrite = 1'b0; s.ex_hold = 1'b0;
    s.id_valid = 1'b1; s.id_rs1 = 5'd0; s.id_rs1_data = 32'h123;
    drive_cycle(s);
    @(negedge clk); #1;
    check("fwd_wb", bus.alu_x, 32'hBB);
    s = idle; s.mem_rd = 5'd0; s.mem_regwrite = 1'b1; s.mem_result = 32'hCC;
    drive_cycle(s);
    @(negedge clk); #1;
    check("fwd_x0", bus.alu_x, 32'd0);

    // Load-use: lw x4 then add x5,x4,x1.
    s = idle; s.id_valid = 1'b1; s.id_rd = 5'd4; s.id_memread = 1'b1; s.id_regwrite = 1'b1;
    drive_cycle(s);
    s = idle; s.id_valid = 1'b1; s.id_rs1 = 5'd4; s.id_rs2 = 5'd1; s.id_rd = 5'd5;
    s.id_rs1_data = 32'h1; s.id_rs2_data = 32'h2; s.id_regwrite = 1'b1;
    drive_cycle(s);
    @(negedge clk); #1;
    check("lu_stall", 32'(bus.stall_id), 32'd1);
    drive_cycle(s);
    @(negedge clk); #1;
    check("lu_bubble", 32'(bus.ex_valid), 32'd0);
    s = idle; s.mem_rd = 5'd4; s.mem_regwrite = 1'b1; s.mem_result = 32'hDEAD;
    drive_cycle(s);
    @(negedge clk); #1;
    check("lu_fwd", bus.alu_x, 32'hDEAD);
    check("lu_valid", 32'(bus.ex_valid), 32'd1);

    // Hold persistence of a value forwarded only in the first held cycle.
    s = idle; s.id_valid = 1'b1; s.id_rs2 = 5'd6; s.id_rs2_data = 32'h10;
    drive_cycle(s);
    for (int i = 0; i < 4; i++) begin
      s = idle; s.ex_hold = (i < 3);
      if (i == 0) begin
        s.wb_rd = 5'd6; s.wb_regwrite = 1'b1; s.wb_result = 32'h55;
      end
      drive_cycle(s);
      @(negedge clk); #1;
      check("hold_alu_y", bus.alu_y, 32'h55);
    end

    // Flush beats hold.
    s = idle; s.id_valid = 1'b1; s.id_rd = 5'd7; s.id_regwrite = 1'b1;
    drive_cycle(s);
    s.flush = 1'b1; s.ex_hold = 1'b1;
    drive_cycle(s);
    drive_cycle(idle);
    @(negedge clk); #1;
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_regwrite", 32'(bus.ex_regwrite), 32'd0);

    // Asynchronous reset mid-hold; the first edge after release captures.
    s = idle; s.id_valid = 1'b1; s.id_rs1 = 5'd9; s.id_rs1_data = 32'h77;
    s.id_aluop = 4'b1001; s.id_regwrite = 1'b1;
    drive_cycle(s);
    s = idle; s.ex_hold = 1'b1; s.mem_rd = 5'd9; s.mem_regwrite = 1'b1; s.mem_result = 32'h99;
    drive_cycle(s);
    @(negedge clk); #2;
    check("pre_reset_valid", 32'(bus.ex_valid), 32'd1);
    s = idle; s.id_valid = 1'b1; s.id_rs1 = 5'd3; s.id_rs1_data = 32'h3C; s.id_aluop = 4'b0011;
    async_reset("arst", s);
    drive_cycle(idle);
    @(negedge clk); #1;
    check("post_reset_capture", bus.alu_x, 32'h3C);
    check("post_reset_valid", 32'(bus.ex_valid), 32'd1);

    for (int i = 0; i < 300; i++) drive_cycle(rnd_stim());
    for (int i = 0; i < 3; i++) drive_cycle(idle);
    @(negedge clk); #1;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
